modsub_pipe: RTL and testbench



---
 rtl/modarith_pkg.sv | 11 +
 rtl/modsub_corr.sv | 19 +
 rtl/modsub_pipe.sv | 111 +++++++++++
 tb/tb_modsub_pipe.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/modarith_pkg.sv
// Shared constants for the modular arithmetic library (adder, subtractor, butterflies).
package modarith_pkg;

  localparam int unsigned       MODARITH_MWIDTH = 39;
  localparam logic [38:0]       MODARITH_MOD    = 39'h40_0080_0001;

  // Pipeline depths seen by schedulers that align parallel arithmetic paths.
  localparam int unsigned COMMON_MODADD_DELAY = 1;
  localparam int unsigned COMMON_MODSUB_DELAY = 2;

endpackage

// File: rtl/modsub_corr.sv
// Combinational borrow correction: turns a raw (diff, borrow) pair into a result in [0, MOD).
module modsub_corr
  import modarith_pkg::*;
#(
  parameter int unsigned       MWIDTH = MODARITH_MWIDTH,
  parameter logic [MWIDTH-1:0] MOD    = MWIDTH'(MODARITH_MOD)
) (
  input  logic [MWIDTH-1:0] diff,
  input  logic              borrow,
  output logic [MWIDTH-1:0] result
);

  // A borrow means the true difference is negative; adding MOD wraps it back into range.
  always_comb begin
    result = diff;
    if (borrow) result = diff + MOD;
  end

endmodule

// File: rtl/modsub_pipe.sv
// Two-stage elastic modular subtractor with valid/ready on both sides.
// Optional sticky operand range check enabled by defining MODSUB_RANGE_CHK_EN.
module modsub_pipe
  import modarith_pkg::*;
#(
  parameter int unsigned       MWIDTH = MODARITH_MWIDTH,
  parameter logic [MWIDTH-1:0] MOD    = MWIDTH'(MODARITH_MOD),
  parameter int unsigned       TWIDTH = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_sub_vld,
  output logic              o_sub_rdy,
  input  logic [MWIDTH-1:0] i_sub_din_0,
  input  logic [MWIDTH-1:0] i_sub_din_1,
  input  logic [TWIDTH-1:0] i_sub_tag,
  output logic              o_sub_vld,
  input  logic              i_sub_rdy,
  output logic [MWIDTH-1:0] o_sub_dout,
  output logic [TWIDTH-1:0] o_sub_tag,
  output logic              o_sub_err
);

  logic              s1_vld;
  logic [MWIDTH-1:0] s1_diff;
  logic              s1_borrow;
  logic [TWIDTH-1:0] s1_tag;

  logic              s2_vld;
  logic [MWIDTH-1:0] s2_dout;
  logic [TWIDTH-1:0] s2_tag;

  logic              s1_adv;
  logic              s2_adv;
  logic              accept;
  logic [MWIDTH:0]   diff_full;
  logic [MWIDTH-1:0] corr_result;

  assign s2_adv    = !s2_vld || i_sub_rdy;
  assign s1_adv    = s1_vld && s2_adv;
  assign o_sub_rdy = !s1_vld || s1_adv;
  assign accept    = i_sub_vld && o_sub_rdy;

  // One extra bit so the MSB is the borrow out of the subtraction.
  assign diff_full = {1'b0, i_sub_din_0} - {1'b0, i_sub_din_1};

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld <= 1'b0;
    end else if (accept) begin
      s1_vld <= 1'b1;
    end else if (s1_adv) begin
      s1_vld <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      s1_diff   <= diff_full[MWIDTH-1:0];
      s1_borrow <= diff_full[MWIDTH];
      s1_tag    <= i_sub_tag;
    end
  end

  modsub_corr #(
    .MWIDTH (MWIDTH),
    .MOD    (MOD)
  ) u_corr (
    .diff   (s1_diff),
    .borrow (s1_borrow),
    .result (corr_result)
  );

  // Stage 2 zeroes its data when it drains so idle outputs read 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_vld  <= 1'b0;
      s2_dout <= '0;
      s2_tag  <= '0;
    end else if (s1_adv) begin
      s2_vld  <= 1'b1;
      s2_dout <= corr_result;
      s2_tag  <= s1_tag;
    end else if (i_sub_rdy) begin
      s2_vld  <= 1'b0;
      s2_dout <= '0;
      s2_tag  <= '0;
    end
  end

  assign o_sub_vld  = s2_vld;
  assign o_sub_dout = s2_dout;
  assign o_sub_tag  = s2_tag;

`ifdef MODSUB_RANGE_CHK_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (accept && ((i_sub_din_0 >= MOD) || (i_sub_din_1 >= MOD))) begin
      err_q <= 1'b1;
    end
  end

  assign o_sub_err = err_q;
`else
  assign o_sub_err = 1'b0;
`endif

endmodule

// File: tb/tb_modsub_pipe.sv
// Randomized + directed bench for modsub_pipe against a queue-based behavioural model.
module tb_modsub_pipe;

  localparam int unsigned MW  = 39;
  localparam logic [38:0] MOD = 39'h40_0080_0001;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_sub_vld = 1'b0;
  logic          o_sub_rdy;
  logic [MW-1:0] i_sub_din_0 = '0;
  logic [MW-1:0] i_sub_din_1 = '0;
  logic [0:0]    i_sub_tag = '0;
  logic          o_sub_vld;
  logic          i_sub_rdy = 1'b0;
  logic [MW-1:0] o_sub_dout;
  logic [0:0]    o_sub_tag;
  logic          o_sub_err;

  modsub_pipe #(.MWIDTH(MW), .MOD(MOD), .TWIDTH(1)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_sub_vld   (i_sub_vld),
    .o_sub_rdy   (o_sub_rdy),
    .i_sub_din_0 (i_sub_din_0),
    .i_sub_din_1 (i_sub_din_1),
    .i_sub_tag   (i_sub_tag),
    .o_sub_vld   (o_sub_vld),
    .i_sub_rdy   (i_sub_rdy),
    .o_sub_dout  (o_sub_dout),
    .o_sub_tag   (o_sub_tag),
    .o_sub_err   (o_sub_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] res;
    logic        tag;
    bit          care;
    int unsigned acc;
  } op_t;

  op_t         q[$];
  int unsigned cyc = 0;
  logic        err_exp = 1'b0;
  int          n_checks = 0;
  int          n_pass = 0;
  int          n_acc = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [63:0] ref_sub(input logic [63:0] a, input logic [63:0] b);
    return (a + {25'd0, MOD} - b) % {25'd0, MOD};
  endfunction

  // One clock: drive inputs, check outputs against the model, then advance the model.
  task automatic step(input logic v, input logic [63:0] a, input logic [63:0] b,
                      input logic t, input logic r);
    logic exp_rdy, exp_vld;
    op_t  op;
    i_sub_vld   = v;
    i_sub_din_0 = a[MW-1:0];
    i_sub_din_1 = b[MW-1:0];
    i_sub_tag   = t;
    i_sub_rdy   = r;
    #1;
    exp_rdy = (q.size() < 2) || r;
    exp_vld = (q.size() > 0) && (cyc - q[0].acc >= 2);
    check("rdy", {63'd0, o_sub_rdy}, {63'd0, exp_rdy});
    check("vld", {63'd0, o_sub_vld}, {63'd0, exp_vld});
    if (exp_vld) begin
      if (q[0].care) check("dout", {25'd0, o_sub_dout}, q[0].res);
      check("tag", {63'd0, o_sub_tag}, {63'd0, q[0].tag});
    end else begin
      check("dout_idle", {25'd0, o_sub_dout}, 64'd0);
      check("tag_idle", {63'd0, o_sub_tag}, 64'd0);
    end
    check("err", {63'd0, o_sub_err}, {63'd0, err_exp});
    @(posedge clk);
    if (rst) begin
      q.delete();
      err_exp = 1'b0;
    end else begin
      if (exp_vld && r) void'(q.pop_front());
      if (v && exp_rdy) begin
        op.care = (a < {25'd0, MOD}) && (b < {25'd0, MOD});
        op.res  = op.care ? ref_sub(a, b) : 64'd0;
        op.tag  = t;
        op.acc  = cyc;
        q.push_back(op);
        n_acc++;
`ifdef MODSUB_RANGE_CHK_EN
        if (!op.care) err_exp = 1'b1;
`endif
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  function automatic logic [63:0] rnd_op();
    logic [63:0] x;
    x = {$urandom, $urandom};
    return x % {25'd0, MOD};
  endfunction

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state.
    check("reset_vld", {63'd0, o_sub_vld}, 64'd0);
    check("reset_dout", {25'd0, o_sub_dout}, 64'd0);
    check("reset_err", {63'd0, o_sub_err}, 64'd0);

    // 5 - 3 with 2-cycle latency and tag preserved.
    step(1'b1, 64'd5, 64'd3, 1'b1, 1'b1);
    step(1'b0, 64'd0, 64'd0, 1'b0, 1'b1);
    check("sub_5_3", {25'd0, o_sub_dout}, 64'd2);
    check("sub_5_3_tag", {63'd0, o_sub_tag}, 64'd1);
    step(1'b0, 64'd0, 64'd0, 1'b0, 1'b1);

    // Boundary values, each checked against a literal at its output cycle.
    step(1'b1, 64'd3, 64'd5, 1'b0, 1'b1);
    step(1'b1, 64'd0, {25'd0, MOD} - 64'd1, 1'b1, 1'b1);
    check("sub_3_5", {25'd0, o_sub_dout}, 64'h40_007F_FFFF);
    step(1'b1, 64'd7, 64'd7, 1'b0, 1'b1);
    check("sub_0_modm1", {25'd0, o_sub_dout}, 64'd1);
    step(1'b0, 64'd0, 64'd0, 1'b0, 1'b1);
    check("sub_7_7", {25'd0, o_sub_dout}, 64'd0);
    step(1'b0, 64'd0, 64'd0, 1'b0, 1'b1);

    // Back-to-back stream of 8 with the sink always ready.
    n_acc = 0;
    for (int i = 0; i < 8; i++) step(1'b1, rnd_op(), rnd_op(), 1'($urandom), 1'b1);
    check("stream_accepts", 64'(n_acc), 64'd8);
    repeat (3) step(1'b0, 64'd0, 64'd0, 1'b0, 1'b1);

    // Sink stalled for 5 cycles with the source always valid.
    n_acc = 0;
    for (int i = 0; i < 5; i++) step(1'b1, rnd_op(), rnd_op(), 1'($urandom), 1'b0);
    check("stall_accepts", 64'(n_acc), 64'd2);
    for (int i = 0; i < 4; i++) step(1'b1, rnd_op(), rnd_op(), 1'($urandom), 1'b1);
    repeat (3) step(1'b0, 64'd0, 64'd0, 1'b0, 1'b1);
    check("stall_drained", 64'(q.size()), 64'd0);

    // Reset with two ops in flight: neither may be emitted.
    step(1'b1, 64'd11, 64'd4, 1'b1, 1'b0);
    step(1'b1, 64'd12, 64'd4, 1'b1, 1'b0);
    rst = 1'b1;
    step(1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
    rst = 1'b0;
    check("rst_vld", {63'd0, o_sub_vld}, 64'd0);
    check("rst_dout", {25'd0, o_sub_dout}, 64'd0);
    repeat (4) step(1'b0, 64'd0, 64'd0, 1'b0, 1'b1);

    // Randomized traffic with random backpressure.
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 9) < 7), rnd_op(), rnd_op(), 1'($urandom),
           1'($urandom_range(0, 9) < 6));
    repeat (4) step(1'b0, 64'd0, 64'd0, 1'b0, 1'b1);

    // Out-of-range operand: sticky error only when the range check is built in.
    step(1'b1, {25'd0, MOD}, 64'd0, 1'b0, 1'b1);
`ifdef MODSUB_RANGE_CHK_EN
    check("err_set", {63'd0, o_sub_err}, 64'd1);
`else
    check("err_tied", {63'd0, o_sub_err}, 64'd0);
`endif
    for (int i = 0; i < 6; i++) step(1'b1, rnd_op(), rnd_op(), 1'b0, 1'b1);
    rst = 1'b1;
    step(1'b0, 64'd0, 64'd0, 1'b0, 1'b1);
    rst = 1'b0;
    check("err_cleared", {63'd0, o_sub_err}, 64'd0);
    repeat (3) step(1'b0, 64'd0, 64'd0, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
